// File: rtl/cdb_arbiter_if.sv
// Handshake between the completing functional units and the CDB arbiter,
// plus the registered CDB broadcast that the arbiter drives back out.
interface cdb_arbiter_if #(
    parameter int N_FU  = 4,
    parameter int TAG_W = 6
);
    localparam int FU_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ready;
        logic             valid;
    } tag_t;

    logic [N_FU-1:0]       fu_valid;
    logic [N_FU*TAG_W-1:0] fu_tag;
    logic [N_FU-1:0]       fu_ready;
    tag_t                  cdb;
    logic [FU_W-1:0]       cdb_fu;

    modport master (output fu_valid, fu_tag, input fu_ready, cdb, cdb_fu);
    modport slave  (input fu_valid, fu_tag, output fu_ready, cdb, cdb_fu);
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU completion FIFOs feeding a round-robin arbiter that broadcasts one
// tag per cycle on the registered CDB.
module cdb_arbiter #(
    parameter int N_FU      = 4,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         squash,
    cdb_arbiter_if.slave bus
);
    localparam int FU_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [TAG_W-1:0] mem_q    [N_FU][BUF_DEPTH];
    logic [TAG_W-1:0] mem_d    [N_FU][BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [N_FU];
    logic [PTR_W-1:0] rd_ptr_d [N_FU];
    logic [PTR_W-1:0] wr_ptr_q [N_FU];
    logic [PTR_W-1:0] wr_ptr_d [N_FU];
    logic [CNT_W-1:0] count_q  [N_FU];
    logic [CNT_W-1:0] count_d  [N_FU];

    logic [FU_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [FU_W-1:0]  cdb_fu_q, cdb_fu_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic             cdb_valid_q, cdb_valid_d;

    logic [TAG_W-1:0] in_tag [N_FU];
    logic [N_FU-1:0]  eligible;
    logic [N_FU-1:0]  ready;
    logic [N_FU-1:0]  push;
    logic [N_FU-1:0]  pop;

    logic             grant_valid;
    logic [FU_W-1:0]  grant_idx;
    logic [FU_W:0]    scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_FU; gi++) begin : g_fu
            assign in_tag[gi]   = bus.fu_tag[gi*TAG_W +: TAG_W];
            assign eligible[gi] = (count_q[gi] != '0);
            // Ready looks only at the registered count, so a full FIFO popped
            // this cycle still refuses the handoff until the next cycle.
            assign ready[gi]    = (count_q[gi] < CNT_W'(BUF_DEPTH));
            assign push[gi]     = bus.fu_valid[gi] & ready[gi] & ~squash;
            assign pop[gi]      = grant_valid && (grant_idx == FU_W'(gi));
        end
    endgenerate

    assign bus.fu_ready = ready;
    assign bus.cdb      = {cdb_tag_q, cdb_valid_q, cdb_valid_q};
    assign bus.cdb_fu   = cdb_fu_q;

    // Scan rr_ptr, rr_ptr+1, ... (mod N_FU) and take the first non-empty FIFO.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_FU; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (FU_W+1)'(k);
            if (scan_idx >= (FU_W+1)'(N_FU)) begin
                scan_idx = scan_idx - (FU_W+1)'(N_FU);
            end
            if (!grant_valid && eligible[scan_idx[FU_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[FU_W-1:0];
            end
        end
    end

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_fu_d    = cdb_fu_q;
        cdb_tag_d   = '0;
        cdb_valid_d = 1'b0;
        if (squash) begin
            for (int i = 0; i < N_FU; i++) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = in_tag[i];
                    wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                end
                unique case ({push[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                    2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                    default: count_d[i] = count_q[i];
                endcase
            end
            if (grant_valid) begin
                cdb_tag_d   = mem_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_valid_d = 1'b1;
                cdb_fu_d    = grant_idx;
                rr_ptr_d    = (grant_idx == FU_W'(N_FU - 1)) ? '0 : grant_idx + FU_W'(1);
            end
        end
    end

    // Storage carries no reset; emptiness is tracked by the counters alone.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_FU; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_fu_q    <= '0;
            cdb_tag_q   <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_fu_q    <= cdb_fu_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_valid_q <= cdb_valid_d;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int N_FU  = 4;
    localparam int DEPTH = 2;
    localparam int TAG_W = 6;
    localparam int WMAX  = 64;

    logic clock;
    logic reset;
    logic squash;

    cdb_arbiter_if #(.N_FU(N_FU), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.N_FU(N_FU), .BUF_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-FU ordered buffer, round-robin pointer, expected CDB.
    logic [TAG_W-1:0] mbuf [N_FU][DEPTH];
    int               mcnt [N_FU];
    int               rr;
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    int               e_fu;

    // What each FU still wants to hand off, oldest first.
    logic [TAG_W-1:0] want_buf [N_FU][WMAX];
    int               want_n   [N_FU];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic want(input int fu, input logic [TAG_W-1:0] tag);
        if (want_n[fu] < WMAX) begin
            want_buf[fu][want_n[fu]] = tag;
            want_n[fu]++;
        end
    endtask

    task automatic cycle(input bit rst_n, input bit sq, input bit force_all);
        logic [N_FU-1:0]  vld;
        logic [N_FU-1:0]  rdy;
        logic [TAG_W-1:0] tg [N_FU];
        logic [N_FU-1:0]  exp_ready;
        int win;
        int idx;
        reset  = rst_n;
        squash = sq;
        for (int i = 0; i < N_FU; i++) begin
            if (force_all) begin
                vld[i] = 1'b1;
                tg[i]  = 6'h3f;
            end else if (want_n[i] > 0) begin
                vld[i] = 1'b1;
                tg[i]  = want_buf[i][0];
            end else begin
                vld[i] = 1'b0;
                tg[i]  = TAG_W'($urandom);
            end
            bus.fu_valid[i] = vld[i];
            bus.fu_tag[i*TAG_W +: TAG_W] = tg[i];
            rdy[i] = (mcnt[i] < DEPTH);
        end
        @(posedge clock);
        if (!rst_n) begin
            for (int i = 0; i < N_FU; i++) mcnt[i] = 0;
            rr = 0; e_valid = 1'b0; e_tag = '0; e_fu = 0;
        end else if (sq) begin
            for (int i = 0; i < N_FU; i++) mcnt[i] = 0;
            e_valid = 1'b0; e_tag = '0;
        end else begin
            win = -1;
            for (int k = 0; k < N_FU; k++) begin
                idx = (rr + k) % N_FU;
                if (win < 0 && mcnt[idx] > 0) win = idx;
            end
            if (win >= 0) begin
                e_tag = mbuf[win][0];
                for (int j = 0; j < DEPTH - 1; j++) mbuf[win][j] = mbuf[win][j+1];
                mcnt[win]--;
                e_valid = 1'b1;
                e_fu    = win;
                rr      = (win + 1) % N_FU;
            end else begin
                e_valid = 1'b0;
                e_tag   = '0;
            end
            for (int i = 0; i < N_FU; i++) begin
                if (vld[i] && rdy[i]) begin
                    mbuf[i][mcnt[i]] = tg[i];
                    mcnt[i]++;
                end
            end
        end
        if (!force_all) begin
            for (int i = 0; i < N_FU; i++) begin
                if (vld[i] && rdy[i]) begin
                    for (int j = 0; j < WMAX - 1; j++) want_buf[i][j] = want_buf[i][j+1];
                    want_n[i]--;
                end
            end
        end
        for (int i = 0; i < N_FU; i++) exp_ready[i] = (mcnt[i] < DEPTH);
        #1;
        chk("cdb_valid", 32'(bus.cdb.valid), 32'(e_valid));
        chk("cdb_ready", 32'(bus.cdb.ready), 32'(e_valid));
        chk("cdb_tag",   32'(bus.cdb.tag),   32'(e_tag));
        chk("cdb_fu",    32'(bus.cdb_fu),    32'(e_fu));
        chk("fu_ready",  32'(bus.fu_ready),  32'(exp_ready));
        $display("t=%0t rst=%0b sq=%0b valid=%b cdb_valid=%0b tag=%0d fu=%0d ready=%b",
                 $time, rst_n, sq, vld, bus.cdb.valid, bus.cdb.tag, bus.cdb_fu, bus.fu_ready);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        squash = 1'b0;
        bus.fu_valid = '0;
        bus.fu_tag = '0;
        rr = 0; e_valid = 1'b0; e_tag = '0; e_fu = 0;
        for (int i = 0; i < N_FU; i++) begin
            mcnt[i] = 0;
            want_n[i] = 0;
        end

        // Reset held two edges with every FU valid: nothing may get through.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("reset_ready", 32'(bus.fu_ready), 32'hf);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Contention from rr_ptr=0: 10,11,12,13 on consecutive cycles.
        for (int i = 0; i < N_FU; i++) want(i, TAG_W'(10 + i));
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < N_FU; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            chk("contend_tag", 32'(bus.cdb.tag), 32'(10 + k));
            chk("contend_fu",  32'(bus.cdb_fu),  32'(k));
        end
        cycle(1'b1, 1'b0, 1'b0);

        // Single ALU completion: two-edge latency, one cycle on the bus.
        want(0, 6'd5);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("single_tag", 32'(bus.cdb.tag), 32'd5);
        chk("single_fu",  32'(bus.cdb_fu),  32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("single_gone", 32'(bus.cdb.valid), 32'd0);

        // Backpressure: LD holds 22 until its FIFO drains while FP1 streams.
        want(3, 6'd20); want(3, 6'd21); want(3, 6'd22);
        for (int k = 0; k < 8; k++) want(1, TAG_W'(30 + k));
        repeat (14) cycle(1'b1, 1'b0, 1'b0);

        // Squash with three tags buffered.
        want(0, 6'd40); want(1, 6'd41); want(2, 6'd42);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("squash_valid", 32'(bus.cdb.valid), 32'd0);
        chk("squash_ready", 32'(bus.fu_ready),  32'hf);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Fairness between LD and ALU with pointer wrap.
        for (int k = 0; k < 8; k++) begin
            want(3, TAG_W'(50 + k));
            want(0, TAG_W'(60 + k));
        end
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Reset wins over a simultaneous squash and drops buffered tags.
        want(0, 6'd7); want(1, 6'd8);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("rst_sq_fu", 32'(bus.cdb_fu), 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Random traffic with occasional squash and reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N_FU; i++) begin
                if (want_n[i] < 8 && $urandom_range(0, 99) < 35) want(i, TAG_W'($urandom_range(1, 63)));
            end
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
